// File: rtl/sorted_list_serializer.sv
// sorted_list_serializer
//
// Captures one ascending list of up to DEPTH metrics in a single load handshake, then
// streams the entries out smallest first, one per cycle, over a valid/ready interface.
// Each loaded list is checked for non-decreasing order, and a sticky flag records any
// violation.
//
// Ports:
//   i_clk, i_rst     clock (rising edge), synchronous active-high reset
//   i_load_valid     list present on i_load_data / i_load_count
//   o_load_ready     a list can be accepted this cycle (combinational)
//   i_load_data      flattened list, entry k at [k*DATA_W +: DATA_W], entry 0 smallest
//   i_load_count     number of valid entries starting at entry 0 (clamped to DEPTH)
//   i_flush          abort the current list; overrides pop and load
//   o_valid/i_ready  output handshake
//   o_data, o_index  current entry and its 0-based position in the list
//   o_last           current entry is the final one of its list
//   o_busy           a list is being drained
//   o_order_err      sticky: some loaded list was not non-decreasing
module sorted_list_serializer #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load_valid,
    output logic                    o_load_ready,
    input  logic [DEPTH*DATA_W-1:0] i_load_data,
    input  logic [CNT_W-1:0]        i_load_count,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_W-1:0]       o_data,
    output logic [CNT_W-1:0]        o_index,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_order_err
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W-1:0] buf_d [DEPTH];
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;

    logic              drain;
    logic              pop;
    logic              load_accept;
    logic              order_bad;
    logic [CNT_W-1:0]  eff_count;

    assign drain       = (state_q == StDrain);
    assign eff_count   = (i_load_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_load_count;

    // Outputs are gated by the drain state so IDLE always presents zeros.
    assign o_valid     = drain;
    assign o_busy      = drain;
    assign o_data      = drain ? buf_q[0] : '0;
    assign o_index     = drain ? idx_q : '0;
    assign o_last      = drain && (rem_q == CNT_W'(1));
    assign o_order_err = err_q;

    // A new list may be taken while the last beat of the current one transfers,
    // which gives back-to-back lists without a bubble.
    assign o_load_ready = !i_rst && !i_flush && (!drain || (o_last && i_ready));
    assign load_accept  = i_load_valid && o_load_ready;
    assign pop          = drain && i_ready;

    // Only adjacent pairs inside the effective count take part in the order check.
    always_comb begin
        order_bad = 1'b0;
        for (int k = 1; k < int'(DEPTH); k++) begin
            if ((CNT_W'(k) < eff_count) &&
                (i_load_data[k*DATA_W +: DATA_W] < i_load_data[(k-1)*DATA_W +: DATA_W])) begin
                order_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        err_d   = err_q;
        for (int k = 0; k < int'(DEPTH); k++) begin
            buf_d[k] = buf_q[k];
        end

        if (i_flush) begin
            state_d = StIdle;
            rem_d   = '0;
            idx_d   = '0;
        end else if (load_accept) begin
            if (eff_count == '0) begin
                // Empty list: accepted as a no-op.
                state_d = StIdle;
                rem_d   = '0;
                idx_d   = '0;
            end else begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    buf_d[k] = (CNT_W'(k) < eff_count) ? i_load_data[k*DATA_W +: DATA_W] : '0;
                end
                rem_d   = eff_count;
                idx_d   = '0;
                state_d = StDrain;
                err_d   = err_q | order_bad;
            end
        end else if (pop) begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                buf_d[k] = buf_q[k+1];
            end
            buf_d[DEPTH-1] = '0;
            idx_d          = idx_q + CNT_W'(1);
            rem_d          = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_sorted_list_serializer.sv
// Testbench for sorted_list_serializer. The stimulus side pushes the expected beats of
// every accepted list into a queue; a monitor on the falling edge pops and compares on
// each output transfer and tracks the sticky order flag.
module tb_sorted_list_serializer;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned DEPTH  = 6;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LIST_W = DEPTH * DATA_W;

    logic              i_clk        = 1'b0;
    logic              i_rst        = 1'b1;
    logic              i_load_valid = 1'b0;
    logic              o_load_ready;
    logic [LIST_W-1:0] i_load_data  = '0;
    logic [CNT_W-1:0]  i_load_count = '0;
    logic              i_flush      = 1'b0;
    logic              o_valid;
    logic              i_ready      = 1'b1;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_index;
    logic              o_last;
    logic              o_busy;
    logic              o_order_err;

    sorted_list_serializer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load_valid(i_load_valid),
        .o_load_ready(o_load_ready),
        .i_load_data (i_load_data),
        .i_load_count(i_load_count),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_index     (o_index),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_order_err (o_order_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  index;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    checks      = 0;
    int    failures    = 0;
    logic  exp_err     = 1'b0;
    logic  err_pending = 1'b0;

    // Reference model: a list contributes min(count, DEPTH) beats in order, and any
    // adjacent descending pair inside that range raises the sticky flag.
    function automatic void model_load(input logic [LIST_W-1:0] d, input logic [CNT_W-1:0] c);
        int    eff;
        beat_t b;
        eff = (int'(c) > int'(DEPTH)) ? int'(DEPTH) : int'(c);
        for (int k = 0; k < eff; k++) begin
            b.data  = d[k*DATA_W +: DATA_W];
            b.index = k[CNT_W-1:0];
            b.last  = (k == eff - 1);
            exp_q.push_back(b);
            if (k > 0 && d[k*DATA_W +: DATA_W] < d[(k-1)*DATA_W +: DATA_W]) begin
                err_pending = 1'b1;
            end
        end
    endfunction

    function automatic logic [LIST_W-1:0] pack(input int unsigned v [DEPTH]);
        logic [LIST_W-1:0] r;
        int unsigned       t;
        r = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            t = v[k];
            r[k*DATA_W +: DATA_W] = t[DATA_W-1:0];
        end
        return r;
    endfunction

    // Ready pattern generator: 0 always ready, 1 random, 2 repeating 1,0,0.
    int ready_mode  = 0;
    int ready_phase = 0;
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    i_ready = ((ready_phase % 3) == 0);
                    ready_phase++;
                end
            endcase
        end
    end

    // Monitor
    beat_t held;
    bit    hold_pending = 0;
    bit    expect_valid = 0;
    always @(negedge i_clk) begin
        beat_t got;
        beat_t want;
        got = {o_data, o_index, o_last};
        checks++;
        if (o_order_err !== exp_err) begin
            failures++;
            $display("FAIL order_err: got %b want %b", o_order_err, exp_err);
        end
        checks++;
        if (o_valid !== expect_valid) begin
            failures++;
            $display("FAIL valid: got %b want %b", o_valid, expect_valid);
        end
        checks++;
        if (o_busy !== o_valid) begin
            failures++;
            $display("FAIL busy: got %b want %b", o_busy, o_valid);
        end
        if (i_rst) begin
            checks++;
            if (o_load_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_ready_in_reset: got %b want 0", o_load_ready);
            end
        end
        if (hold_pending) begin
            checks++;
            if (o_valid !== 1'b1 || got !== held) begin
                failures++;
                $display("FAIL hold: got v=%b d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                         o_valid, got.data, got.index, got.last,
                         held.data, held.index, held.last);
            end
        end
        hold_pending = 0;
        if (i_rst) begin
            exp_q.delete();
            exp_err     = 1'b0;
            err_pending = 1'b0;
        end else begin
            if (i_flush) begin
                exp_q.delete();
            end else if (o_valid === 1'b1) begin
                if (i_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL beat: got d=%0d i=%0d l=%b want no beat",
                                 got.data, got.index, got.last);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("FAIL beat: got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                                     got.data, got.index, got.last,
                                     want.data, want.index, want.last);
                        end
                    end
                end else begin
                    hold_pending = 1;
                    held         = got;
                end
            end
            exp_err     = exp_err | err_pending;
            err_pending = 1'b0;
        end
        expect_valid = (exp_q.size() > 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_load_valid = 1'b0;
            i_flush      = 1'b0;
            i_rst        = 1'b0;
        end
    endtask

    // Holds the list on the load port until it is accepted (bounded).
    task automatic present(input logic [LIST_W-1:0] d, input logic [CNT_W-1:0] c,
                           output int waited, output logic last_at_acc,
                           output logic [DATA_W-1:0] data_at_acc);
        bit acc;
        acc         = 0;
        waited      = 0;
        last_at_acc = 1'b0;
        data_at_acc = '0;
        while (!acc && waited < 100) begin
            @(posedge i_clk);
            #1;
            i_load_valid = 1'b1;
            i_load_data  = d;
            i_load_count = c;
            i_flush      = 1'b0;
            i_rst        = 1'b0;
            #1;
            waited++;
            if (o_load_ready === 1'b1) begin
                acc         = 1;
                last_at_acc = o_last;
                data_at_acc = o_data;
                model_load(d, c);
            end
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL load_timeout: got no accept in %0d cycles want accept", waited);
            i_load_valid = 1'b0;
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        int                w;
        logic              la;
        logic [DATA_W-1:0] da;
        logic [LIST_W-1:0] l_main;
        logic [LIST_W-1:0] d;
        int unsigned       v;
        int unsigned       cnt;

        l_main = pack('{3, 7, 7, 12, 20, 900});

        // Reset
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        expect_bit("reset_valid", o_valid, 1'b0);
        expect_bit("reset_busy", o_busy, 1'b0);
        expect_bit("reset_last", o_last, 1'b0);
        expect_bit("reset_err", o_order_err, 1'b0);
        expect_bit("reset_data_zero", (o_data == '0 && o_index == '0), 1'b1);
        expect_bit("idle_load_ready", o_load_ready, 1'b1);

        // Full list, always ready
        ready_mode = 0;
        present(l_main, 3'd6, w, la, da);
        idle(8);

        // Same list with stalls
        ready_mode  = 2;
        ready_phase = 0;
        present(l_main, 3'd6, w, la, da);
        idle(22);

        // Back-to-back lists
        ready_mode = 0;
        present(pack('{1, 2, 0, 0, 0, 0}), 3'd2, w, la, da);
        present(pack('{5, 6, 8, 0, 0, 0}), 3'd3, w, la, da);
        expect_bit("b2b_accept_cycle", (w == 2), 1'b1);
        expect_bit("b2b_accept_on_last", la, 1'b1);
        expect_bit("b2b_accept_data", (da == DATA_W'(2)), 1'b1);
        idle(6);

        // Empty list and over-long count
        present(l_main, 3'd0, w, la, da);
        idle(1);
        #1;
        expect_bit("count0_no_valid", o_valid, 1'b0);
        present(pack('{11, 22, 33, 44, 55, 66}), 3'd7, w, la, da);
        idle(9);

        // Ordering violation, then a good list: flag stays set
        present(pack('{10, 4, 15, 1, 0, 0}), 3'd3, w, la, da);
        idle(1);
        #1;
        expect_bit("order_err_set", o_order_err, 1'b1);
        idle(4);
        present(pack('{1, 2, 3, 4, 5, 6}), 3'd6, w, la, da);
        idle(8);
        #1;
        expect_bit("order_err_sticky", o_order_err, 1'b1);

        // Flush on the second beat while a load is offered
        present(l_main, 3'd6, w, la, da);
        idle(1);
        @(posedge i_clk);
        #1;
        i_flush      = 1'b1;
        i_load_valid = 1'b1;
        i_load_data  = pack('{1, 1, 1, 1, 1, 1});
        i_load_count = 3'd3;
        #1;
        expect_bit("flush_second_beat", (o_index == CNT_W'(1)), 1'b1);
        expect_bit("flush_load_ready", o_load_ready, 1'b0);
        idle(1);
        #1;
        expect_bit("flush_valid", o_valid, 1'b0);
        expect_bit("flush_busy", o_busy, 1'b0);
        idle(2);

        // Reset mid-drain
        present(l_main, 3'd6, w, la, da);
        idle(2);
        @(posedge i_clk);
        #1;
        i_rst        = 1'b1;
        i_load_valid = 1'b0;
        idle(1);
        #1;
        expect_bit("rst_mid_valid", o_valid, 1'b0);
        expect_bit("rst_mid_err", o_order_err, 1'b0);
        expect_bit("rst_mid_zero", (o_data == '0 && o_index == '0 && !o_last && !o_busy), 1'b1);
        idle(2);

        // Randomised lists
        ready_mode = 1;
        for (int it = 0; it < 150; it++) begin
            v = $urandom_range(0, 100);
            for (int k = 0; k < int'(DEPTH); k++) begin
                d[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
                if ($urandom_range(0, 9) == 0) begin
                    v = $urandom_range(0, 1023);
                end else begin
                    v = v + $urandom_range(0, 3) * $urandom_range(0, 60);
                    if (v > 1023) v = 1023;
                end
            end
            cnt = $urandom_range(0, 7);
            present(d, cnt[CNT_W-1:0], w, la, da);
            if ($urandom_range(0, 9) == 0) begin
                @(posedge i_clk);
                #1;
                i_load_valid = 1'b0;
                i_flush      = 1'b1;
                idle(1);
            end else begin
                idle($urandom_range(0, 3));
            end
        end

        ready_mode = 0;
        idle(15);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_complete: got %0d beats outstanding want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
